regfile_dump_tx: RTL and testbench
==================================

Name: regfile_dump_tx

Overview:
- Reader and transmitter for the 32x8 CPU register file.
- On a start pulse, walks read addresses FIRST_ADDR..LAST_ADDR through one register-file read port (src/rdata).
- Serialises each byte as UART 8N1, LSB first, on `tx`.
- Gives host-side visibility of register contents (GPRs, STEP/STEPADDR, counter and flag registers) without halting the datapath.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535
- FIRST_ADDR, 0, first register address dumped (5-bit)
- LAST_ADDR, 31, last register address dumped (5-bit); must satisfy LAST_ADDR >= FIRST_ADDR

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-low reset
- start  input  1  request a dump; sampled every cycle, ignored while busy=1
- src  output  5  read address to register-file read port
- rdata  input  8  combinational read data for `src`, valid in the same cycle
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at end of dump
- tx  output  1  UART serial out, idle high

Behaviour:
- Reset: rst=0 at a posedge forces the following outputs and state:
  - state=IDLE, tx=1, busy=0, done=0, src=FIRST_ADDR
  - bit counter, baud counter and shift register = 0
  - A reset mid-dump aborts immediately. tx returns to 1 even mid-bit, and no partial byte is completed.
- States: IDLE, FETCH, START, DATA, STOP, (CSUM when enabled), FIN.
- IDLE:
  - tx=1, src held at FIRST_ADDR.
  - start=1 at a posedge -> FETCH, busy=1, address counter=FIRST_ADDR.
- FETCH (exactly 1 cycle):
  - src=address counter; shift register <= rdata at the closing edge.
  - Next state START.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Then DATA with bit index 0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles, then shift right.
  - After bit 7 completes -> STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - Then: if address counter==LAST_ADDR -> FIN (or CSUM if enabled); else address counter+1 -> FETCH.
- FIN (1 cycle): done=1, busy=0, tx=1, then IDLE.
  - busy falls in the same cycle done rises.
- Timing:
  - Each byte costs 1 + 10*CLKS_PER_BIT cycles.
  - Full dump = N*(1+10*CLKS_PER_BIT) + 1 cycles from the first busy=1 cycle through done, where N = LAST_ADDR-FIRST_ADDR+1.
  - tx falls for the first start bit 2 cycles after start is sampled (IDLE->FETCH->START).
- Coherency: each byte is a snapshot taken in its FETCH cycle. Register writes after FETCH are not reflected in that byte. Writes to a not-yet-fetched address are reflected.
- Simultaneous events:
  - start during busy is dropped, not queued.
  - start in the FIN cycle is dropped.
  - start on the cycle after FIN is accepted.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The address counter never wraps past LAST_ADDR.
- src is driven only in FETCH and held stable otherwise; its value outside FETCH is don't-care to the register file.

Optional Feature:
- Macro: REGDUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all dumped bytes is cleared on start acceptance and accumulated at each FETCH.
  - After the last STOP, state CSUM sends the two's-complement of the sum (so data+checksum ≡ 0 mod 256) as one more 8N1 frame.
  - Then FIN; dump length grows by 10*CLKS_PER_BIT cycles.
- Not defined: no CSUM state or sum register; STOP of the last byte goes directly to FIN.

Test Plan:
- Reset defaults: CLKS_PER_BIT=4; preload reg0=0x5A; rst=0 for 3 cycles -> tx=1, busy=0, done=0 throughout; no activity for 50 cycles after rst=1 without start.
- Single byte: FIRST_ADDR=LAST_ADDR=0, reg0=0x5A, pulse start -> tx sequence 0,0,1,0,1,1,0,1,0,1 (start, LSB-first 0x5A, stop), each 4 cycles; done 1 cycle after stop; busy high 42 cycles.
- Full dump: regfile[i]=i*3 for i=0..31, default range -> bench UART decoder receives 32 bytes 0x00,0x03,...,0x5D in order; done exactly once at cycle 32*41+1 after busy rises.
- Start while busy: pulse start again at byte 5 -> dump unaffected, no second dump, exactly 32 bytes received.
- Reset mid-dump: assert rst during DATA of byte 3 -> tx=1 and busy=0 the next cycle; new start gives full dump from FIRST_ADDR.
- Checksum (REGDUMP_CHECKSUM_EN): regs 0..2 = 0x10,0x20,0x30, LAST_ADDR=2 -> 4 frames, last = 0xA0; with macro undefined -> 3 frames only.

Source files
------------

// File: rtl/regfile_dump_tx.sv
// Walks a register-file read port and streams each byte out as UART 8N1.
// Optional trailing two's-complement checksum frame: define REGDUMP_CHECKSUM_EN.
module regfile_dump_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [4:0] FIRST_ADDR   = 5'd0,
    parameter logic [4:0] LAST_ADDR    = 5'd31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] src,
    input  logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP,
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    state_t      r_state;
    logic [4:0]  r_addr;
    logic [4:0]  r_src;
    logic [15:0] r_baud;
    logic [3:0]  r_bitIdx;
    logic [7:0]  r_shift;
    logic        r_busy;
    logic        r_done;
    logic        r_tx;
`ifdef REGDUMP_CHECKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic w_baudWrap;
    assign w_baudWrap = (r_baud == BAUD_LAST);

    assign src  = r_src;
    assign busy = r_busy;
    assign done = r_done;
    assign tx   = r_tx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_addr   <= FIRST_ADDR;
            r_src    <= FIRST_ADDR;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tx     <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            r_sum    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_done <= 1'b0;
                    r_src  <= FIRST_ADDR;
                    if (start) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                        r_addr  <= FIRST_ADDR;
`ifdef REGDUMP_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                // The byte is snapshotted here; the start bit begins on the next cycle.
                S_FETCH: begin
                    r_shift <= rdata;
`ifdef REGDUMP_CHECKSUM_EN
                    r_sum   <= r_sum + rdata;
`endif
                    r_tx    <= 1'b0;
                    r_baud  <= '0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_baudWrap) begin
                        r_baud   <= '0;
                        r_bitIdx <= '0;
                        r_tx     <= r_shift[0];
                        r_state  <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_baudWrap) begin
                        r_baud <= '0;
                        if (r_bitIdx == 4'd7) begin
                            r_bitIdx <= '0;
                            r_tx     <= 1'b1;
                            r_state  <= S_STOP;
                        end else begin
                            r_shift  <= r_shift >> 1;
                            r_tx     <= r_shift[1];
                            r_bitIdx <= r_bitIdx + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_baudWrap) begin
                        r_baud <= '0;
                        if (r_addr == LAST_ADDR) begin
`ifdef REGDUMP_CHECKSUM_EN
                            r_shift  <= ~r_sum + 8'd1;
                            r_tx     <= 1'b0;
                            r_bitIdx <= '0;
                            r_state  <= S_CSUM;
`else
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
`endif
                        end else begin
                            r_addr  <= r_addr + 5'd1;
                            r_src   <= r_addr + 5'd1;
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                // Whole checksum frame in one state: index 0 start, 1..8 data, 9 stop.
                S_CSUM: begin
                    if (w_baudWrap) begin
                        r_baud <= '0;
                        case (r_bitIdx)
                            4'd0: begin
                                r_tx     <= r_shift[0];
                                r_bitIdx <= 4'd1;
                            end
                            4'd8: begin
                                r_tx     <= 1'b1;
                                r_bitIdx <= 4'd9;
                            end
                            4'd9: begin
                                r_bitIdx <= '0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= S_FIN;
                            end
                            default: begin
                                r_shift  <= r_shift >> 1;
                                r_tx     <= r_shift[1];
                                r_bitIdx <= r_bitIdx + 4'd1;
                            end
                        endcase
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
`endif
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_tx    <= 1'b1;
                    r_src   <= FIRST_ADDR;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench for regfile_dump_tx: three instances (single byte, full range, three bytes)
// sharing one clock and reset, with a UART receiver per instance.
module tb_regfile_dump_tx;

    localparam int CPB      = 4;
    localparam int FRAME    = 10 * CPB;
    localparam int BYTE_CYC = 1 + FRAME;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       startA, startB, startC;
    logic [4:0] srcA, srcB, srcC;
    logic [7:0] rdataA, rdataB, rdataC;
    logic       busyA, busyB, busyC;
    logic       doneA, doneB, doneC;
    logic       txA, txB, txC;

    logic [7:0] memA [32];
    logic [7:0] memB [32];
    logic [7:0] memC [32];

    assign rdataA = memA[srcA];
    assign rdataB = memB[srcB];
    assign rdataC = memC[srcC];

    logic txs [3];
    assign txs[0] = txA;
    assign txs[1] = txB;
    assign txs[2] = txC;

    logic [7:0] rxBytes [3][64];
    int         rxCount [3];

    int vectors;
    int miscompares;

    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_ADDR(5'd0), .LAST_ADDR(5'd0)) dutA (
        .clk(clk), .rst(rst), .start(startA), .src(srcA), .rdata(rdataA),
        .busy(busyA), .done(doneA), .tx(txA)
    );

    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_ADDR(5'd0), .LAST_ADDR(5'd31)) dutB (
        .clk(clk), .rst(rst), .start(startB), .src(srcB), .rdata(rdataB),
        .busy(busyB), .done(doneB), .tx(txB)
    );

    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_ADDR(5'd0), .LAST_ADDR(5'd2)) dutC (
        .clk(clk), .rst(rst), .start(startC), .src(srcC), .rdata(rdataC),
        .busy(busyC), .done(doneC), .tx(txC)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int d);
        case (d)
            0: startA = 1'b1;
            1: startB = 1'b1;
            default: startC = 1'b1;
        endcase
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
    endtask

    // Samples mid-bit; frames with a bad stop bit are not recorded.
    task automatic rxMonitor(input int d);
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (rst && txs[d] === 1'b0) begin
                for (int i = 1; i <= 38; i++) begin
                    @(negedge clk);
                    if (i >= 6 && i <= 34 && ((i - 6) % 4) == 0) b[(i - 6) / 4] = txs[d];
                end
                if (txs[d] === 1'b1 && rxCount[d] < 64) begin
                    rxBytes[d][rxCount[d]] = b;
                    rxCount[d]++;
                end
            end
        end
    endtask

    task automatic singleByte();
        logic [7:0] expByte;
        logic [3:0] bits;
        logic       expBit;
        int         span;
        int         doneCount;
        expByte   = 8'h5A;
        span      = -1;
        doneCount = 0;
        rxCount[0] = 0;
        applyStimulus(0);
        checkOutput("a_busy_rise", busyA, 1);
        checkOutput("a_fetch_tx", txA, 1);
        for (int slot = 0; slot < 10; slot++) begin
            bits = '0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                bits = {bits[2:0], txA};
            end
            if (slot == 0)      expBit = 1'b0;
            else if (slot == 9) expBit = 1'b1;
            else                expBit = expByte[slot - 1];
            checkOutput($sformatf("a_slot%0d", slot), bits, expBit ? 4'hF : 4'h0);
        end
        for (int t = 41; t < 200; t++) begin
            @(negedge clk);
            if (doneA) begin
                doneCount++;
                if (span < 0) begin
                    span = t + 1;
                    checkOutput("a_busy_at_done", busyA, 0);
                    checkOutput("a_tx_at_done", txA, 1);
                end
            end
        end
        checkOutput("a_span", span, 42 + CS * FRAME);
        checkOutput("a_done_count", doneCount, 1);
        checkOutput("a_rx_count", rxCount[0], 1 + CS);
        checkOutput("a_rx_byte", rxBytes[0][0], 8'h5A);
    endtask

    task automatic fullDumpB(input bit pokeAgain, input string tag);
        int span;
        int doneCount;
        int total;
        span      = -1;
        doneCount = 0;
        total     = 32 * BYTE_CYC + 1 + CS * FRAME + 60;
        rxCount[1] = 0;
        applyStimulus(1);
        for (int t = 0; t < total; t++) begin
            if (t > 0) @(negedge clk);
            if (pokeAgain) startB = (t == 5 * BYTE_CYC + 10);
            if (doneB) begin
                doneCount++;
                if (span < 0) span = t + 1;
            end
        end
        startB = 1'b0;
        checkOutput({tag, "_span"}, span, 32 * BYTE_CYC + 1 + CS * FRAME);
        checkOutput({tag, "_done_count"}, doneCount, 1);
        checkOutput({tag, "_busy_after"}, busyB, 0);
        checkOutput({tag, "_rx_count"}, rxCount[1], 32 + CS);
        for (int i = 0; i < 32; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), rxBytes[1][i], 8'(i * 3));
`ifdef REGDUMP_CHECKSUM_EN
        checkOutput({tag, "_csum"}, rxBytes[1][32], 8'h30);
`endif
    endtask

    task automatic resetMidDump();
        applyStimulus(1);
        repeat (3 * BYTE_CYC + 10) @(negedge clk);
        checkOutput("r_busy_before", busyB, 1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("r_tx", txB, 1);
        checkOutput("r_busy", busyB, 0);
        checkOutput("r_done", doneB, 0);
        checkOutput("r_src", srcB, 0);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("r_stays_idle", busyB, 0);
        rxCount[1] = 0;
    endtask

    task automatic checksumTest();
        int doneCount;
        doneCount  = 0;
        rxCount[2] = 0;
        applyStimulus(2);
        for (int t = 0; t < 3 * BYTE_CYC + FRAME + 80; t++) begin
            @(negedge clk);
            if (doneC) doneCount++;
        end
        checkOutput("c_done_count", doneCount, 1);
        checkOutput("c_rx_count", rxCount[2], 3 + CS);
        checkOutput("c_byte0", rxBytes[2][0], 8'h10);
        checkOutput("c_byte1", rxBytes[2][1], 8'h20);
        checkOutput("c_byte2", rxBytes[2][2], 8'h30);
`ifdef REGDUMP_CHECKSUM_EN
        checkOutput("c_csum", rxBytes[2][3], 8'hA0);
`endif
    endtask

    initial begin
        int idleBad;
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
        for (int i = 0; i < 3; i++) rxCount[i] = 0;
        for (int i = 0; i < 32; i++) begin
            memA[i] = 8'h00;
            memB[i] = 8'(i * 3);
            memC[i] = 8'h00;
        end
        memA[0] = 8'h5A;
        memC[0] = 8'h10;
        memC[1] = 8'h20;
        memC[2] = 8'h30;

        fork
            rxMonitor(0);
            rxMonitor(1);
            rxMonitor(2);
        join_none

        $display("[TB] reset defaults");
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_tx", txB, 1);
            checkOutput("rst_busy", busyB, 0);
            checkOutput("rst_done", doneB, 0);
        end
        checkOutput("rst_src", srcB, 0);
        rst = 1'b1;
        idleBad = 0;
        repeat (50) begin
            @(negedge clk);
            if (txA !== 1'b1 || txB !== 1'b1 || txC !== 1'b1 ||
                busyA !== 1'b0 || busyB !== 1'b0 || busyC !== 1'b0 ||
                doneA !== 1'b0 || doneB !== 1'b0 || doneC !== 1'b0)
                idleBad++;
        end
        checkOutput("idle_quiet", idleBad, 0);

        $display("[TB] single byte");
        singleByte();
        $display("[TB] full dump with extra start while busy");
        fullDumpB(1'b1, "b1");
        $display("[TB] reset mid-dump");
        resetMidDump();
        fullDumpB(1'b0, "b2");
        $display("[TB] three-byte range");
        checksumTest();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
